// File: rtl/rs_decode_sequencer.sv
// Control sequencer for the 15/11 Reed-Solomon decoder over GF(16): load/syndrome, Euclid solve,
// Chien/Forney evaluation and corrected-message readout. Holds no GF arithmetic.
module rs_decode_sequencer #(
  parameter int unsigned N           = 15,
  parameter int unsigned K           = 11,
  parameter int unsigned EUC_TIMEOUT = 31,
  parameter int unsigned T           = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic       SYN_CLR,
  output logic       SYN_EN,
  input  logic       SYN_ZERO,
  output logic       EUC_START,
  input  logic       EUC_DONE,
  input  logic [2:0] ERR_LOC_DEG,
  output logic       CHIEN_LOAD,
  output logic       CHIEN_EN,
  input  logic [2:0] ROOT_CNT,
  output logic       BUF_WR_EN,
  output logic [3:0] BUF_WR_ADDR,
  output logic [3:0] BUF_RD_ADDR,
  output logic       CORR_EN,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       OUT_LAST,
  output logic       DEC_FAIL,
  output logic       BUSY
);

  localparam logic [4:0] LastSym = 5'(N - 1);
  localparam logic [4:0] EucLast = 5'(EUC_TIMEOUT - 1);
  localparam logic [3:0] LastOut = 4'(K - 1);
  localparam logic [2:0] MaxDeg  = 3'(T);

  typedef enum logic [6:0] {
    StIdle  = 7'b0000001,
    StLoad  = 7'b0000010,
    StEval  = 7'b0000100,
    StEuc   = 7'b0001000,
    StChien = 7'b0010000,
    StFin   = 7'b0100000,
    StOut   = 7'b1000000
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] sym_cnt_q, sym_cnt_d;
  logic [4:0] cyc_cnt_q, cyc_cnt_d;
  logic [2:0] deg_q, deg_d;
  logic       dec_fail_q, dec_fail_d;
  logic       corr_en_q, corr_en_d;
  logic [3:0] rd_addr_q, rd_addr_d;

  logic in_ready, euc_start, chien_load, chien_en, out_valid;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      sym_cnt_q  <= '0;
      cyc_cnt_q  <= '0;
      deg_q      <= '0;
      dec_fail_q <= 1'b0;
      corr_en_q  <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      deg_q      <= deg_d;
      dec_fail_q <= dec_fail_d;
      corr_en_q  <= corr_en_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sym_cnt_d  = sym_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    deg_d      = deg_q;
    dec_fail_d = dec_fail_q;
    corr_en_d  = corr_en_q;
    rd_addr_d  = rd_addr_q;
    in_ready   = 1'b0;
    euc_start  = 1'b0;
    chien_load = 1'b0;
    chien_en   = 1'b0;
    out_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (IN_VALID) begin
          sym_cnt_d = 5'd1;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        if (IN_VALID) begin
          if (sym_cnt_q == LastSym) begin
            sym_cnt_d = '0;
            state_d   = StEval;
          end else begin
            sym_cnt_d = sym_cnt_q + 5'd1;
          end
        end
      end
      StEval: begin
        if (SYN_ZERO) begin
          corr_en_d = 1'b0;
          rd_addr_d = '0;
          state_d   = StOut;
        end else begin
          euc_start = 1'b1;
          cyc_cnt_d = '0;
          state_d   = StEuc;
        end
      end
      StEuc: begin
        // A done pulse on the final timeout cycle still counts as success.
        if (EUC_DONE) begin
          deg_d     = ERR_LOC_DEG;
          cyc_cnt_d = '0;
          rd_addr_d = '0;
          if (ERR_LOC_DEG > MaxDeg) begin
            dec_fail_d = 1'b1;
            state_d    = StOut;
          end else begin
            chien_load = 1'b1;
            state_d    = StChien;
          end
        end else if (cyc_cnt_q == EucLast) begin
          dec_fail_d = 1'b1;
          cyc_cnt_d  = '0;
          rd_addr_d  = '0;
          state_d    = StOut;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 5'd1;
        end
      end
      StChien: begin
        chien_en = 1'b1;
        if (cyc_cnt_q == LastSym) begin
          cyc_cnt_d = '0;
          rd_addr_d = '0;
          state_d   = StFin;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 5'd1;
          rd_addr_d = rd_addr_q + 4'd1;
        end
      end
      StFin: begin
        if (ROOT_CNT == deg_q) begin
          corr_en_d = 1'b1;
        end else begin
          dec_fail_d = 1'b1;
          corr_en_d  = 1'b0;
        end
        rd_addr_d = '0;
        state_d   = StOut;
      end
      StOut: begin
        out_valid = 1'b1;
        if (OUT_READY) begin
          if (rd_addr_q == LastOut) begin
            rd_addr_d  = '0;
            corr_en_d  = 1'b0;
            dec_fail_d = 1'b0;
            state_d    = StIdle;
          end else begin
            rd_addr_d = rd_addr_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign IN_READY    = in_ready;
  assign SYN_CLR     = (state_q == StIdle);
  assign SYN_EN      = IN_VALID & in_ready;
  assign BUF_WR_EN   = IN_VALID & in_ready;
  assign BUF_WR_ADDR = sym_cnt_q[3:0];
  assign BUF_RD_ADDR = rd_addr_q;
  assign EUC_START   = euc_start;
  assign CHIEN_LOAD  = chien_load;
  assign CHIEN_EN    = chien_en;
  assign CORR_EN     = corr_en_q;
  assign OUT_VALID   = out_valid;
  assign OUT_LAST    = out_valid & (rd_addr_q == LastOut);
  assign DEC_FAIL    = dec_fail_q;
  assign BUSY        = (state_q != StIdle);

endmodule

// File: tb/tb_rs_decode_sequencer.sv
// Bench for rs_decode_sequencer: directed and random codewords, each checked cycle by cycle
// against a timing model derived from the phase lengths of a decode.
module tb_rs_decode_sequencer;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       IN_VALID, IN_READY, SYN_CLR, SYN_EN, SYN_ZERO;
  logic       EUC_START, EUC_DONE, CHIEN_LOAD, CHIEN_EN;
  logic [2:0] ERR_LOC_DEG, ROOT_CNT;
  logic       BUF_WR_EN;
  logic [3:0] BUF_WR_ADDR, BUF_RD_ADDR;
  logic       CORR_EN, OUT_VALID, OUT_READY, OUT_LAST, DEC_FAIL, BUSY;

  int n_cmp = 0;
  int n_err = 0;

  rs_decode_sequencer dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .SYN_CLR(SYN_CLR), .SYN_EN(SYN_EN), .SYN_ZERO(SYN_ZERO), .EUC_START(EUC_START),
    .EUC_DONE(EUC_DONE), .ERR_LOC_DEG(ERR_LOC_DEG), .CHIEN_LOAD(CHIEN_LOAD),
    .CHIEN_EN(CHIEN_EN), .ROOT_CNT(ROOT_CNT), .BUF_WR_EN(BUF_WR_EN),
    .BUF_WR_ADDR(BUF_WR_ADDR), .BUF_RD_ADDR(BUF_RD_ADDR), .CORR_EN(CORR_EN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST),
    .DEC_FAIL(DEC_FAIL), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, BUSY, 0);
    check({tag, " in_ready"}, IN_READY, 1);
    check({tag, " syn_clr"}, SYN_CLR, 1);
    check({tag, " out_valid"}, OUT_VALID, 0);
    check({tag, " out_last"}, OUT_LAST, 0);
    check({tag, " dec_fail"}, DEC_FAIL, 0);
    check({tag, " corr_en"}, CORR_EN, 0);
    check({tag, " chien_en"}, CHIEN_EN, 0);
    check({tag, " euc_start"}, EUC_START, 0);
    check({tag, " rd_addr"}, BUF_RD_ADDR, 0);
    check({tag, " wr_addr"}, BUF_WR_ADDR, 0);
  endtask

  // d: cycles from EUC_START to the EUC_DONE pulse; outside 1..31 the solver never finishes.
  // gap_mode: 0 = IN_VALID held, 1 = toggling, 2 = random. stall_mode: 0 none, 1 random,
  // 2 = four-cycle stalls on beats 3 and 11. rst_at >= 0 pulses reset at that Chien step.
  task automatic run_cw(input string name, input bit syn_zero, input int d,
                        input logic [2:0] deg, input logic [2:0] roots,
                        input int gap_mode, input int stall_mode, input int rst_at);
    int acc = 0, hs = 0, eval_cyc = 0, stall_left, lat, rel;
    bit eval_set = 0, aborted = 0, timeout, chien_path, exp_fail, exp_corr;
    bit wr, ov_exp, cen_exp;
    int stall[11];

    timeout    = (d < 1) || (d > 31);
    chien_path = !syn_zero && !timeout && (deg <= 3'd2);
    exp_corr   = chien_path && (roots == deg);
    exp_fail   = !syn_zero && !exp_corr;
    if (syn_zero)        lat = 1;
    else if (timeout)    lat = 32;
    else if (deg > 3'd2) lat = d + 1;
    else                 lat = d + 17;
    for (int b = 0; b < 11; b++)
      stall[b] = (stall_mode == 1) ? int'($urandom_range(0, 2)) :
                 (stall_mode == 2 && (b == 2 || b == 10)) ? 4 : 0;
    stall_left  = stall[0];
    SYN_ZERO    = syn_zero;
    ERR_LOC_DEG = deg;
    ROOT_CNT    = roots;

    for (int cyc = 0; cyc < 600 && hs < 11 && !aborted; cyc++) begin
      @(negedge CLK);
      if (acc < 15)
        IN_VALID = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? ((cyc % 2) == 0) :
                   ($urandom_range(0, 2) != 0);
      else
        IN_VALID = 1'($urandom_range(0, 1));
      rel       = eval_set ? cyc - eval_cyc : -1;
      EUC_DONE  = !syn_zero && !timeout && eval_set && (rel == d);
      OUT_READY = (stall_left == 0);
      #1;
      wr      = IN_VALID && (acc < 15);
      cen_exp = chien_path && eval_set && (rel >= d + 1) && (rel <= d + 15);
      ov_exp  = eval_set && (rel >= lat);

      check({name, " in_ready"}, IN_READY, acc < 15);
      check({name, " syn_en"}, SYN_EN, wr);
      check({name, " buf_wr_en"}, BUF_WR_EN, wr);
      if (wr) check({name, " buf_wr_addr"}, BUF_WR_ADDR, acc);
      check({name, " busy"}, BUSY, acc > 0);
      check({name, " syn_clr"}, SYN_CLR, acc == 0);
      check({name, " euc_start"}, EUC_START, !syn_zero && eval_set && rel == 0);
      check({name, " chien_load"}, CHIEN_LOAD, chien_path && eval_set && rel == d);
      check({name, " chien_en"}, CHIEN_EN, cen_exp);
      if (cen_exp) check({name, " chien rd_addr"}, BUF_RD_ADDR, rel - d - 1);
      check({name, " out_valid"}, OUT_VALID, ov_exp);
      if (ov_exp) begin
        check({name, " out rd_addr"}, BUF_RD_ADDR, hs);
        check({name, " out_last"}, OUT_LAST, hs == 10);
        check({name, " dec_fail"}, DEC_FAIL, exp_fail);
        check({name, " corr_en"}, CORR_EN, exp_corr);
      end else begin
        check({name, " out_last idle"}, OUT_LAST, 0);
      end
      if (acc < 15) begin
        check({name, " load dec_fail"}, DEC_FAIL, 0);
        check({name, " load corr_en"}, CORR_EN, 0);
      end

      if (rst_at >= 0 && cen_exp && (rel - d - 1) == rst_at) begin
        IN_VALID = 1'b0;
        EUC_DONE = 1'b0;
        #1 RESET_N = 1'b0;
        #1;
        check_idle({name, " async reset"});
        check({name, " async reset chien_load"}, CHIEN_LOAD, 0);
        check({name, " async reset wr_en"}, BUF_WR_EN, 0);
        aborted = 1;
      end else begin
        if (wr) begin
          if (acc == 14) begin
            eval_set = 1;
            eval_cyc = cyc + 1;
          end
          acc++;
        end
        if (ov_exp) begin
          if (OUT_READY) begin
            hs++;
            if (hs < 11) stall_left = stall[hs];
          end else begin
            stall_left--;
          end
        end
      end
    end

    if (aborted) begin
      @(negedge CLK);
      RESET_N = 1'b1;
    end else begin
      check({name, " handshakes"}, hs, 11);
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    EUC_DONE = 1'b0;
    #1;
    check_idle({name, " after"});
  endtask

  initial begin
    logic [2:0] rdeg, rroots;
    int         rd;
    bit         rzero;

    RESET_N     = 1'b0;
    IN_VALID    = 1'b0;
    SYN_ZERO    = 1'b0;
    EUC_DONE    = 1'b0;
    ERR_LOC_DEG = '0;
    ROOT_CNT    = '0;
    OUT_READY   = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check_idle("reset");
    check("reset syn_en", SYN_EN, 0);
    check("reset chien_load", CHIEN_LOAD, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    run_cw("clean",        1'b1, 0,  3'd0, 3'd0, 0, 0, -1);
    run_cw("single",       1'b0, 12, 3'd1, 3'd1, 0, 0, -1);
    run_cw("root_mismatch", 1'b0, 7, 3'd2, 3'd1, 0, 0, -1);
    run_cw("euc_timeout",  1'b0, 0,  3'd1, 3'd1, 0, 0, -1);
    run_cw("backpressure", 1'b0, 5,  3'd2, 3'd2, 1, 2, -1);
    run_cw("reset_chien",  1'b0, 3,  3'd1, 3'd1, 0, 0, 7);
    run_cw("post_reset",   1'b0, 12, 3'd1, 3'd1, 0, 0, -1);
    run_cw("done_at_limit", 1'b0, 31, 3'd2, 3'd2, 0, 0, -1);
    run_cw("deg_over_t",   1'b0, 4,  3'd3, 3'd3, 0, 0, -1);
    run_cw("deg_zero",     1'b0, 1,  3'd0, 3'd0, 2, 1, -1);
    run_cw("clean_stall",  1'b1, 0,  3'd0, 3'd0, 2, 2, -1);

    for (int i = 0; i < 16; i++) begin
      rzero  = ($urandom_range(0, 3) == 0);
      rd     = int'($urandom_range(0, 33));
      rdeg   = 3'($urandom_range(0, 4));
      rroots = $urandom_range(0, 1) ? rdeg : 3'($urandom_range(0, 7));
      run_cw("random", rzero, rd, rdeg, rroots, int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
